// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Byte-wide instruction fetch sequencer for a small 8-bit core.
//
// Each instruction passes through four states:
//   FETCH_OP  -> DECODE -> [FETCH_IMM] -> ISSUE
//
// FETCH_OP  reads the opcode byte at PC into the instruction register.
// FETCH_IMM is visited only when the controller reports an immediate byte.
// ISSUE     pulses instr_valid_o for one cycle and may redirect the PC.
//
// Memory handshake:
//   - imem_req_o and imem_addr_o come straight from the state and the PC
//     register, so they cannot move until the acknowledging clock edge.
//   - An acknowledge that arrives outside a request state is ignored,
//     because only the request states look at imem_ack_i.
//   - The PC wraps naturally in 8 bits, from 8'hFF to 8'h00.
//
// Optional feature (compile-time macro FETCH_STALL_EN):
//   - Adds the stall_i input.
//   - While stall_i is high, ISSUE is held: no pulse and no PC update.
//   - Without the macro, ISSUE always lasts exactly one cycle.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       imem_req_o,
    output logic [7:0] imem_addr_o,
    input  logic       imem_ack_i,
    input  logic [7:0] imem_data_i,
    output logic [3:0] opcode_o,
    output logic [3:0] operand_o,
    output logic [7:0] immediate_o,
    input  logic       en_immediate_i,
    input  logic       en_jmp_i,
    input  logic       jmp_taken_i,
    output logic       instr_valid_o,
    output logic [7:0] pc_o
`ifdef FETCH_STALL_EN
    ,
    input  logic       stall_i
`endif
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        DECODE    = 2'd1,
        FETCH_IMM = 2'd2,
        ISSUE     = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] pc_reg,    pc_next;
    logic [7:0] ir_reg,    ir_next;
    logic [7:0] imm_reg,   imm_next;
    logic       stall_active;
    logic       jump_redirect;

`ifdef FETCH_STALL_EN
    assign stall_active = stall_i;
`else
    assign stall_active = 1'b0;
`endif

    // Only a taken jump redirects the PC; a not-taken jump falls through.
    assign jump_redirect = en_jmp_i & jmp_taken_i;

    // State and datapath registers; reset lands in FETCH_OP at RESET_PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= FETCH_OP;
            pc_reg    <= RESET_PC;
            ir_reg    <= 8'h00;
            imm_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            imm_reg   <= imm_next;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        imm_next      = imm_reg;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;

        case (state_reg)
            FETCH_OP: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_next    = imem_data_i;
                    pc_next    = pc_reg + 8'd1;
                    state_next = DECODE;
                end
            end

            DECODE: begin
                // The controller has now seen the opcode; ask it about the
                // immediate byte.
                state_next = en_immediate_i ? FETCH_IMM : ISSUE;
            end

            FETCH_IMM: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    imm_next   = imem_data_i;
                    pc_next    = pc_reg + 8'd1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (!stall_active) begin
                    instr_valid_o = 1'b1;
                    if (jump_redirect) begin
                        pc_next = imm_reg;
                    end
                    state_next = FETCH_OP;
                end
            end

            default: begin
                state_next = FETCH_OP;
            end
        endcase
    end

    // The address always follows the PC, which is what keeps it stable
    // for the whole duration of a pending request.
    assign imem_addr_o = pc_reg;
    assign pc_o        = pc_reg;
    assign immediate_o = imm_reg;

    // Split the instruction register into its opcode and operand nibbles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ir_split
            assign operand_o[gi] = ir_reg[gi];
            assign opcode_o[gi]  = ir_reg[gi + 4];
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed and randomized checks of fetch_unit against an instruction-level
// reference model. The model keeps a 256-byte program image, together with
// the expected PC, instruction byte and immediate byte.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       imem_req_o;
    logic [7:0] imem_addr_o;
    logic       imem_ack_i;
    logic [7:0] imem_data_i;
    logic [3:0] opcode_o;
    logic [3:0] operand_o;
    logic [7:0] immediate_o;
    logic       en_immediate_i;
    logic       en_jmp_i;
    logic       jmp_taken_i;
    logic       instr_valid_o;
    logic [7:0] pc_o;
`ifdef FETCH_STALL_EN
    logic       stall_i;
`endif

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .opcode_o       (opcode_o),
        .operand_o      (operand_o),
        .immediate_o    (immediate_o),
        .en_immediate_i (en_immediate_i),
        .en_jmp_i       (en_jmp_i),
        .jmp_taken_i    (jmp_taken_i),
        .instr_valid_o  (instr_valid_o),
        .pc_o           (pc_o)
`ifdef FETCH_STALL_EN
        ,
        .stall_i        (stall_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    logic [7:0] mem [256];
    logic [7:0] exp_pc;
    logic [7:0] exp_ir;
    logic [7:0] exp_imm;
    int         lat;
    int         checks = 0;
    int         errors = 0;
    int         n_instr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One memory read: hold off for w cycles, then acknowledge with the
    // byte at the expected PC. The request must stay stable throughout.
    task automatic fetch_byte(input string tag, input int w, output logic [7:0] val);
        for (int i = 0; i <= w; i++) begin
            chk({tag, "_req"},   {31'd0, imem_req_o},    32'd1);
            chk({tag, "_addr"},  {24'd0, imem_addr_o},   {24'd0, exp_pc});
            chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
            imem_ack_i  = (i == w);
            imem_data_i = (i == w) ? mem[exp_pc] : 8'($urandom);
            @(negedge clk_i);
            lat++;
        end
        imem_ack_i = 1'b0;
        val        = mem[exp_pc];
        exp_pc     = exp_pc + 8'd1;
    endtask

    // Outside request states, drive random acknowledges and data; these
    // must have no effect.
    task automatic noise();
        imem_ack_i  = 1'($urandom);
        imem_data_i = 8'($urandom);
    endtask

    // Runs one full instruction starting in FETCH_OP and checks everything
    // the model predicts, including fetch-to-issue latency.
    task automatic run_instr(input logic imm, input logic jmp, input logic taken,
                             input int w0, input int w1, input int nstall);
        int exp_lat;
        en_immediate_i = imm;
        en_jmp_i       = jmp;
        jmp_taken_i    = taken;
        lat            = 0;
        fetch_byte("op", w0, exp_ir);
        // DECODE
        chk("dec_req",   {31'd0, imem_req_o},    32'd0);
        chk("dec_valid", {31'd0, instr_valid_o}, 32'd0);
        noise();
        @(negedge clk_i);
        lat++;
        if (imm) begin
            fetch_byte("imm", w1, exp_imm);
        end
        // ISSUE, possibly stalled
`ifdef FETCH_STALL_EN
        for (int s = 0; s < nstall; s++) begin
            stall_i = 1'b1;
            #1;
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("stall_pc",    {24'd0, pc_o},          {24'd0, exp_pc});
            noise();
            @(negedge clk_i);
            lat++;
        end
        stall_i = 1'b0;
        #1;
`endif
        exp_lat = 2 + w0 + (imm ? 1 + w1 : 0) + nstall;
        chk("iss_valid",   {31'd0, instr_valid_o}, 32'd1);
        chk("iss_req",     {31'd0, imem_req_o},    32'd0);
        chk("iss_latency", lat,                    exp_lat);
        chk("iss_opcode",  {28'd0, opcode_o},      {28'd0, exp_ir[7:4]});
        chk("iss_operand", {28'd0, operand_o},     {28'd0, exp_ir[3:0]});
        chk("iss_imm",     {24'd0, immediate_o},   {24'd0, exp_imm});
        chk("iss_pc",      {24'd0, pc_o},          {24'd0, exp_pc});
        $display("instr %0d: ir=%02h imm=%02h jmp=%0d taken=%0d pc_after_fetch=%02h lat=%0d",
                 n_instr, exp_ir, exp_imm, jmp, taken, exp_pc, lat + 1);
        n_instr++;
        noise();
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        if (jmp && taken) begin
            exp_pc = exp_imm;
        end
    endtask

    initial begin
        int ns;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
        end
        imem_ack_i     = 1'b0;
        imem_data_i    = 8'h00;
        en_immediate_i = 1'b0;
        en_jmp_i       = 1'b0;
        jmp_taken_i    = 1'b0;
`ifdef FETCH_STALL_EN
        stall_i        = 1'b0;
`endif
        ns = 0;

        // Reset state
        rst_i = 1'b1;
        #1;
        chk("rst_pc",    {24'd0, pc_o},          {24'd0, RESET_PC});
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_ir",    {24'd0, opcode_o, operand_o}, 32'd0);
        chk("rst_imm",   {24'd0, immediate_o},   32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("post_rst_req",  {31'd0, imem_req_o},  32'd1);
        chk("post_rst_addr", {24'd0, imem_addr_o}, {24'd0, RESET_PC});
        exp_pc  = RESET_PC;
        exp_imm = 8'h00;

        // Plain instruction at 0x00
        mem[8'h00] = 8'h9A;
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0);
        // Instruction with immediate at 0x01/0x02
        mem[8'h01] = 8'h2C;
        mem[8'h02] = 8'h55;
        run_instr(1'b1, 1'b0, 1'b0, 0, 0, 0);
        // Taken jump to 0x40
        mem[8'h03] = 8'hC1;
        mem[8'h04] = 8'h40;
        run_instr(1'b1, 1'b1, 1'b1, 0, 0, 0);
        chk("jmp_target", {24'd0, imem_addr_o}, 32'h40);
        // Not-taken jump falls through to 0x42
        mem[8'h41] = 8'h40;
        run_instr(1'b1, 1'b1, 1'b0, 0, 0, 0);
        chk("jmp_fallthru", {24'd0, imem_addr_o}, 32'h42);
        // Slow memory: acknowledge after 3 wait cycles
        run_instr(1'b1, 1'b0, 1'b0, 3, 3, 0);
        // Jump to 0xFF, then fetch there: the PC wraps to 0x00
        mem[exp_pc + 8'd1] = 8'hFF;
        run_instr(1'b1, 1'b1, 1'b1, 1, 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 2, 0, 0);
        chk("wrap_pc", {24'd0, pc_o}, 32'h00);

`ifdef FETCH_STALL_EN
        // Two stall cycles delay the issue pulse
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 2);
`endif

        // Reset while waiting for the immediate byte; then a late ack
        en_immediate_i = 1'b1;
        en_jmp_i       = 1'b0;
        lat            = 0;
        fetch_byte("abort_op", 0, exp_ir);
        @(negedge clk_i);                 // DECODE
        chk("abort_in_imm_req", {31'd0, imem_req_o}, 32'd1);
        @(negedge clk_i);                 // still waiting in FETCH_IMM
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_pc",    {24'd0, pc_o},          {24'd0, RESET_PC});
        chk("abort_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("abort_ir",    {24'd0, opcode_o, operand_o}, 32'd0);
        chk("abort_imm",   {24'd0, immediate_o},   32'd0);
        imem_ack_i  = 1'b1;
        imem_data_i = 8'hEE;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        rst_i      = 1'b0;
        #1;
        exp_pc  = RESET_PC;
        exp_imm = 8'h00;
        for (int i = 0; i < 2; i++) begin
            chk("restart_req",   {31'd0, imem_req_o},    32'd1);
            chk("restart_addr",  {24'd0, imem_addr_o},   {24'd0, RESET_PC});
            chk("restart_valid", {31'd0, instr_valid_o}, 32'd0);
            @(negedge clk_i);
        end
        run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            logic r_imm, r_jmp, r_taken;
            r_imm   = 1'($urandom);
            r_jmp   = ($urandom_range(0, 3) == 0);
            r_taken = 1'($urandom);
`ifdef FETCH_STALL_EN
            ns = $urandom_range(0, 2);
`endif
            run_instr(r_imm, r_jmp, r_taken, $urandom_range(0, 3), $urandom_range(0, 3), ns);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_o, output, 1: instruction memory read request.
REQ-005 SHALL have port imem_addr_o, output, 8: instruction memory byte address.
REQ-006 SHALL have port imem_ack_i, input, 1: read data valid; sampled only while imem_req_o=1.
REQ-007 SHALL have port imem_data_i, input, 8: read data.
REQ-008 SHALL have port opcode_o, output, 4: instruction register bits [7:4], fed to controller opcode_i.
REQ-009 SHALL have port operand_o, output, 4: instruction register bits [3:0].
REQ-010 SHALL have port immediate_o, output, 8: second instruction byte when fetched.
REQ-011 SHALL have port en_immediate_i, input, 1: controller flag, instruction carries an immediate byte.
REQ-012 SHALL have port en_jmp_i, input, 1: controller flag, instruction is a jump.
REQ-013 SHALL have port jmp_taken_i, input, 1: resolved jump condition from flag logic.
REQ-014 SHALL have port instr_valid_o, output, 1: one-cycle pulse, instruction issued to datapath.
REQ-015 SHALL have port pc_o, output, 8: current program counter.

Function
REQ-016 SHALL implement states FETCH_OP, DECODE, FETCH_IMM, ISSUE.
REQ-017 In FETCH_OP: imem_req_o=1, imem_addr_o=PC; on imem_ack_i=1 latch IR<=imem_data_i, PC<=PC+1, go DECODE; else remain.
REQ-018 In DECODE (one cycle): en_immediate_i=1 -> FETCH_IMM; else -> ISSUE.
REQ-019 In FETCH_IMM: imem_req_o=1, imem_addr_o=PC; on ack latch immediate_o<=imem_data_i, PC<=PC+1, go ISSUE.
REQ-020 In ISSUE: instr_valid_o=1 for exactly one cycle; if en_jmp_i=1 and jmp_taken_i=1, PC<=immediate_o; go FETCH_OP.
REQ-021 imem_req_o and imem_addr_o SHALL stay stable from assertion until the acking cycle; imem_req_o=0 in DECODE and ISSUE.
REQ-022 PC increment SHALL wrap 8'hFF -> 8'h00 with no error indication.
REQ-023 imem_ack_i while imem_req_o=0 SHALL be ignored.
REQ-024 immediate_o SHALL hold its last value for instructions without immediate.
REQ-025 Latency with zero-wait memory: 3 cycles per plain instruction, 4 with immediate, FETCH_OP entry to instr_valid_o.
REQ-026 en_jmp_i=1 with jmp_taken_i=0 SHALL continue sequentially at PC.

Reset
REQ-027 rst_i=1 SHALL immediately force state FETCH_OP, PC=RESET_PC, IR=8'h00, immediate_o=8'h00, instr_valid_o=0.
REQ-028 imem_req_o SHALL be 1 with imem_addr_o=RESET_PC in the first cycle after rst_i deasserts; reset mid-fetch abandons the transaction and no stale ack is used.

Configuration
REQ-029 Macro FETCH_STALL_EN defined: port stall_i (input, 1) exists; in ISSUE with stall_i=1 state holds, instr_valid_o=0, PC unchanged; issue occurs on first cycle with stall_i=0.
REQ-030 Macro FETCH_STALL_EN undefined: no stall_i port; ISSUE always lasts one cycle.

Verification
REQ-031 Reset, zero-wait memory, byte 0x00=8'h9A, en_immediate_i=0 -> imem_addr_o=0x00, opcode_o=4'h9, operand_o=4'hA, instr_valid_o pulse 3 cycles after reset release, pc_o=0x01.
REQ-032 Bytes 0x01=8'h2C, 0x02=8'h55, en_immediate_i=1 -> two requests (0x01, 0x02), immediate_o=8'h55, pc_o=0x03, issue 4 cycles after fetch start.
REQ-033 Jump with immediate 8'h40, en_jmp_i=1, jmp_taken_i=1 -> next imem_addr_o=0x40; repeat with jmp_taken_i=0 -> next address sequential.
REQ-034 Memory ack delayed 3 cycles -> imem_addr_o constant and imem_req_o high throughout; PC=0xFF fetch -> pc_o=0x00 afterwards.
REQ-035 rst_i pulsed mid FETCH_IMM, then late ack -> ack ignored, fetch restarts at RESET_PC, no instr_valid_o for aborted instruction.
REQ-036 With FETCH_STALL_EN, stall_i high 2 cycles during ISSUE -> instr_valid_o delayed 2 cycles, single pulse, PC unchanged meanwhile.
